// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package ifetch_pkg;

  localparam int unsigned DEFAULT_DEPTH = 4;

  localparam logic [1:0] SEL_SEQ  = 2'b00;
  localparam logic [1:0] SEL_BEQ  = 2'b01;
  localparam logic [1:0] SEL_JALR = 2'b10;

  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StFlush
  } fetch_state_e;

  function automatic logic [15:0] beq_target(input logic [15:0] pc, input logic [6:0] imm);
    return pc + 16'd1 + {9'b0, imm};
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Single-clock instruction buffer holding {pc, instr} entries; flush empties it at once.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push_i,
  input  logic [31:0]   wdata_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [31:0]   rdata_o,
  output logic [AW:0]   count_o
);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_pop;

  assign do_pop = pop_i && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + (AW+1)'(push_i) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller with credit-limited requests and redirect flushing.
// Define IFETCH_PERF_EN to add saturating fetch/redirect performance counters.
module ifetch_ctrl
  import ifetch_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [15:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [15:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [1:0]  redirect_sel,
  input  logic [15:0] redirect_pc,
  input  logic [6:0]  redirect_imm,
  input  logic [15:0] redirect_target,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [15:0] dec_instr,
  output logic [15:0] dec_pc
`ifdef IFETCH_PERF_EN
  ,
  output logic [15:0] perf_fetch_cnt,
  output logic [15:0] perf_flush_cnt
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_e   state_q, state_d;
  logic [15:0]    pc_q, pc_d;
  logic [CW-1:0]  outst_q, outst_d;
  logic [CW-1:0]  drop_q, drop_d;
  logic [CW-1:0]  buf_cnt;
  logic [31:0]    head;
  logic [15:0]    redir_pc, rsp_pc;
  logic           sel_hit, redir, credit_ok, accept;
  logic           rsp_drop, rsp_keep, rsp_any, push, pop;

  always_comb begin
    sel_hit  = 1'b0;
    redir_pc = redirect_target;
    case (redirect_sel)
      SEL_BEQ: begin
        sel_hit  = 1'b1;
        redir_pc = beq_target(redirect_pc, redirect_imm);
      end
      SEL_JALR: begin
        sel_hit  = 1'b1;
        redir_pc = redirect_target;
      end
      SEL_SEQ, 2'b11: sel_hit = 1'b0;
    endcase
  end

  assign redir     = redirect_valid && sel_hit && (state_q != StBoot);
  assign credit_ok = ((CW+1)'(outst_q) + (CW+1)'(buf_cnt) + (CW+1)'(drop_q)) < (CW+1)'(DEPTH);
  assign imem_req_valid = ((state_q == StRun) || (state_q == StFlush)) && !redir && credit_ok;
  assign imem_req_addr  = pc_q;
  assign accept = imem_req_valid && imem_req_ready;

  // Dropped requests are always older than live ones, so they drain first.
  assign rsp_drop = imem_rsp_valid && (drop_q != '0);
  assign rsp_keep = imem_rsp_valid && (drop_q == '0) && (outst_q != '0);
  assign rsp_any  = rsp_drop || rsp_keep;
  assign push     = rsp_keep && !redir;
  assign pop      = dec_valid && dec_ready;

  // Live requests since the last redirect are sequential, ending just below pc_q.
  assign rsp_pc = pc_q - 16'(outst_q);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    outst_d = outst_q;
    drop_d  = drop_q;
    unique case (state_q)
      StBoot: state_d = StRun;
      StRun, StFlush: begin
        if (redir) begin
          pc_d    = redir_pc;
          outst_d = '0;
          drop_d  = drop_q + outst_q - CW'(rsp_any);
          state_d = (drop_d != '0) ? StFlush : StRun;
        end else begin
          pc_d    = pc_q + 16'(accept);
          outst_d = outst_q + CW'(accept) - CW'(rsp_keep);
          drop_d  = drop_q - CW'(rsp_drop);
          if ((state_q == StFlush) && (drop_d == '0)) state_d = StRun;
        end
      end
      default: state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StBoot;
      pc_q    <= '0;
      outst_q <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
    end
  end

  ifetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push),
    .wdata_i ({rsp_pc, imem_rsp_data}),
    .pop_i   (pop),
    .flush_i (redir),
    .rdata_o (head),
    .count_o (buf_cnt)
  );

  assign dec_valid = (buf_cnt != '0);
  assign dec_pc    = head[31:16];
  assign dec_instr = head[15:0];

`ifdef IFETCH_PERF_EN
  logic [15:0] fetch_cnt_q, fetch_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (accept && (fetch_cnt_q != 16'hFFFF)) fetch_cnt_d = fetch_cnt_q + 16'd1;
    if (redir && (flush_cnt_q != 16'hFFFF)) flush_cnt_d = flush_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: doc/ifetch_ctrl.md
IFETCH_CTRL -- requirements
Module: ifetch_ctrl

Interface
REQ-001 Parameter DEPTH, default 4, instruction buffer entries and max in-flight requests combined; power of two, at least 2.
REQ-002 clk  in  1  clock; all state updates on the rising edge.
REQ-003 reset_n  in  1  reset; asynchronous, active-low.
REQ-004 imem_req_valid  out  1  fetch request valid.
REQ-005 imem_req_ready  in  1  memory accepts the request.
REQ-006 imem_req_addr  out  16  word address of the request.
REQ-007 imem_rsp_valid  in  1  response valid; in order, never back-pressured, at least 1 cycle after acceptance.
REQ-008 imem_rsp_data  in  16  instruction word.
REQ-009 redirect_valid  in  1  control-flow change from execute.
REQ-010 redirect_sel  in  2  01 BEQ taken, 10 JALR; 00 and 11 ignored.
REQ-011 redirect_pc  in  16  PC of the redirecting instruction.
REQ-012 redirect_imm  in  7  BEQ offset, zero-extended.
REQ-013 redirect_target  in  16  JALR target (ALU result).
REQ-014 dec_valid  out  1  instruction available to decode.
REQ-015 dec_ready  in  1  decode consumes the instruction.
REQ-016 dec_instr  out  16  buffered instruction.
REQ-017 dec_pc  out  16  address the instruction was fetched from.

Function
REQ-018 Fetch PC SHALL advance by 1 on every accepted request (imem_req_valid and imem_req_ready), modulo 2^16; 0xFFFF wraps to 0x0000.
REQ-019 imem_req_valid SHALL be high only in RUN or FLUSH, with no redirect that cycle, and outstanding + buffered + dropping < DEPTH (credit rule).
REQ-020 imem_req_valid and imem_req_addr SHALL stay stable until accepted, unless a redirect occurs.
REQ-021 A non-dropped response SHALL be written to the buffer with its request address; the buffer never overflows.
REQ-022 dec_valid SHALL be high when the buffer is non-empty; the head pops on dec_valid and dec_ready; a push and a pop in the same cycle SHALL both take effect.
REQ-023 Response-to-dec_valid latency SHALL be 1 cycle when the buffer is empty.
REQ-024 On redirect_valid with sel 01, the fetch PC SHALL become redirect_pc + 1 + {9'b0, redirect_imm} mod 2^16; with sel 10 it SHALL become redirect_target.
REQ-025 A redirect SHALL empty the buffer, so dec_valid is low the next cycle, and SHALL mark every in-flight request as dropped, excluding any response arriving that same cycle, which is discarded.
REQ-026 Dropped responses SHALL be discarded and decrement the drop counter; requests to the new target MAY issue from the cycle after the redirect.
REQ-027 A redirect with sel 00 or 11 SHALL have no effect.
REQ-028 A redirect in the same cycle as a dec pop SHALL take priority; the pop is the last pre-redirect instruction delivered.
REQ-029 The FSM SHALL have states BOOT, RUN and FLUSH:
- BOOT to RUN after the first clock with reset released; no request issues in BOOT.
- RUN to FLUSH on a redirect with drop count > 0.
- FLUSH to RUN when the drop count reaches 0.
- A redirect in FLUSH SHALL add the new in-flight requests to the drop count.

Reset
REQ-030 Asserting reset_n low SHALL immediately clear: fetch PC 0x0000, state BOOT, buffer empty, outstanding and drop counters 0, imem_req_valid 0, imem_req_addr 0, dec_valid 0, dec_instr 0, dec_pc 0.
REQ-031 Responses to requests issued before a mid-operation reset SHALL NOT be required to be handled.

Configuration
REQ-032 With IFETCH_PERF_EN defined, the block SHALL add outputs perf_fetch_cnt (16) and perf_flush_cnt (16), saturating counts of accepted requests and redirects, reset to 0.
REQ-033 Without IFETCH_PERF_EN, these ports and counters SHALL NOT exist and behaviour is otherwise identical.

Structure
REQ-034 Package ifetch_pkg SHALL hold:
- redirect_sel encodings SEL_SEQ=00, SEL_BEQ=01, SEL_JALR=10;
- the FSM state enum;
- default DEPTH.
REQ-035 The buffer SHALL be a sub-module ifetch_fifo: synchronous, {pc, instr} 32-bit entries, flush input, count output.

Verification
REQ-036 Reset release, imem ready always, 1-cycle response, dec_ready=1 -> addresses 0,1,2,3; dec_pc matches; first dec_valid at cycle 3.
REQ-037 dec_ready=0 with DEPTH=4 -> at most 4 accepted requests, then imem_req_valid low; no instruction lost after dec_ready rises.
REQ-038 BEQ redirect, pc 0x0010, imm 0x05, 2 in flight -> next request addr 0x0016; 2 stale responses dropped; FLUSH to RUN.
REQ-039 JALR redirect to 0xFFFF -> requests 0xFFFF then 0x0000.
REQ-040 Redirect in the same cycle as a response and a dec pop -> the response is discarded, the popped instruction is delivered, the buffer is empty next cycle.
REQ-041 reset_n low mid-FLUSH -> all outputs 0 asynchronously; BOOT; then restart at 0x0000.
